// File: rtl/exhaustive_equiv_checker_pkg.sv
// -----------------------------------------------------------------------------
// exhaustive_equiv_checker_pkg
// Shared constants for the exhaustive equivalence checker:
//   - state_t : checker FSM state encoding (IDLE=0, HOLD=1, CHECK=2, FIN=3)
//   - DEF_N, DEF_SETTLE : default input count and settle time
//   - CNT_W : width of the settle counter (SETTLE is at most 15)
// -----------------------------------------------------------------------------
package exhaustive_equiv_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int DEF_N      = 4;
  localparam int DEF_SETTLE = 1;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/exhaustive_equiv_checker_if.sv
// -----------------------------------------------------------------------------
// exhaustive_equiv_checker_if
// Bundle between the checker and the function pair under test.
//   start      : run request (into the checker)
//   f1, f2     : outputs of the two functions under test (into the checker)
//   x          : stimulus vector, bit 0 is x1 (from the checker)
//   busy, done, pass, err_count, fail_valid, first_fail : run status/results
// Modports: master = checker side, slave = environment / functions side.
// -----------------------------------------------------------------------------
interface exhaustive_equiv_checker_if #(
  parameter int N = exhaustive_equiv_checker_pkg::DEF_N
);
  logic         start;
  logic         f1;
  logic         f2;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         fail_valid;
  logic [N-1:0] first_fail;

  modport master (
    input  start, f1, f2,
    output x, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport slave (
    output start, f1, f2,
    input  x, busy, done, pass, err_count, fail_valid, first_fail
  );
endinterface

// File: rtl/exhaustive_equiv_checker_vector_gen.sv
// -----------------------------------------------------------------------------
// equiv_vector_gen
// Owns the stimulus vector register and the settle counter.
//   Clock, Reset : clock, synchronous active-high reset
//   clear        : x <= 0, counter <= 0 (start of a run)
//   advance      : x <= x + 1, counter <= 0 (move to the next vector)
//   x            : current stimulus vector
//   last         : x is all-ones
//   settled      : counter has reached SETTLE-1
// -----------------------------------------------------------------------------
module equiv_vector_gen
  import exhaustive_equiv_checker_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         clear,
  input  logic         advance,
  output logic [N-1:0] x,
  output logic         last,
  output logic         settled
);

  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  logic [N-1:0]     r_x;
  logic [CNT_W-1:0] r_cnt;

  // The counter saturates at SETTLE-1 so it is harmless while idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_x   <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_x   <= '0;
      r_cnt <= '0;
    end else if (advance) begin
      r_x   <= r_x + N'(1);
      r_cnt <= '0;
    end else if (r_cnt != SETTLE_M1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign x       = r_x;
  assign last    = &r_x;
  assign settled = (r_cnt == SETTLE_M1);

endmodule

// File: rtl/exhaustive_equiv_checker.sv
// -----------------------------------------------------------------------------
// exhaustive_equiv_checker
// Walks every N-bit input vector, holds each for SETTLE cycles, then compares
// f1 against f2 and accumulates the mismatch count and first failing vector.
//   Clock, Reset : clock, synchronous active-high reset (clears all outputs)
//   bus (master) : start/f1/f2 in; x, busy, done, pass, err_count,
//                  fail_valid, first_fail out
// Run length from the start-accept edge to done is 2^N * (SETTLE+1) cycles.
// -----------------------------------------------------------------------------
module exhaustive_equiv_checker
  import exhaustive_equiv_checker_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 Clock,
  input  logic                 Reset,
  exhaustive_equiv_checker_if.master bus
);

  state_t       r_state;
  state_t       w_next;
  logic         w_clear;
  logic         w_advance;
  logic         w_check;
  logic         w_mismatch;
  logic [N-1:0] w_x;
  logic         w_last;
  logic         w_settled;

  logic [N:0]   r_err_count;
  logic         r_fail_valid;
  logic [N-1:0] r_first_fail;

  equiv_vector_gen #(
    .N      (N),
    .SETTLE (SETTLE)
  ) u_vgen (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (w_clear),
    .advance (w_advance),
    .x       (w_x),
    .last    (w_last),
    .settled (w_settled)
  );

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // start is honoured only in IDLE and FIN; in HOLD/CHECK it is ignored.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    w_check   = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (bus.start) begin
          w_clear = 1'b1;
          w_next  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_settled) w_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_check = 1'b1;
        // All-ones test comes first, so x never wraps.
        if (w_last) begin
          w_next = ST_FIN;
        end else begin
          w_advance = 1'b1;
          w_next    = ST_HOLD;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_mismatch = bus.f1 ^ bus.f2;

  // Mismatch accounting; err_count is N+1 bits so 2^N mismatches fit.
  always_ff @(posedge Clock) begin
    if (Reset || w_clear) begin
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
    end else if (w_check && w_mismatch) begin
      r_err_count <= r_err_count + (N+1)'(1);
      if (!r_fail_valid) begin
        r_first_fail <= w_x;
        r_fail_valid <= 1'b1;
      end
    end
  end

  assign bus.x          = w_x;
  assign bus.busy       = (r_state == ST_HOLD) || (r_state == ST_CHECK);
  assign bus.done       = (r_state == ST_FIN);
  assign bus.pass       = (r_state == ST_FIN) && (r_err_count == '0);
  assign bus.err_count  = r_err_count;
  assign bus.fail_valid = r_fail_valid;
  assign bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_exhaustive_equiv_checker.sv
module tb_exhaustive_equiv_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-instance configuration: u0 N=4/S=1, u1 N=4/S=3, u2 N=1/S=1
  localparam int NV [3] = '{4, 4, 1};
  localparam int SV [3] = '{1, 1 + 2, 1};

  int mode [3] = '{0, 0, 0};
  int ph   [3] = '{-1, -1, -1};   // edges since start-accept, -1 = reset/idle

  // ---------------- function pairs under test ----------------
  function automatic logic f1_of(input int m, input int v);
    if (m == 3) return v[0] & v[1];
    return v[0] ^ v[3];
  endfunction

  function automatic logic f2_of(input int m, input int v);
    case (m)
      1:       return (v[0] ^ v[3]) ^ (v == 10);
      2:       return !(v[0] ^ v[3]);
      3:       return v[0] | v[1];
      default: return v[0] ^ v[3];
    endcase
  endfunction

  function automatic int exp_err(input int m, input int nv);
    int c = 0;
    for (int v = 0; v < nv; v++) if (f1_of(m, v) != f2_of(m, v)) c++;
    return c;
  endfunction

  function automatic int exp_first(input int m, input int nv);
    for (int v = 0; v < nv; v++) if (f1_of(m, v) != f2_of(m, v)) return v;
    return 0;
  endfunction

  // ---------------- DUT instances ----------------
  exhaustive_equiv_checker_if #(.N(4)) if0 ();
  exhaustive_equiv_checker_if #(.N(4)) if1 ();
  exhaustive_equiv_checker_if #(.N(1)) if2 ();

  assign if0.f1 = f1_of(mode[0], int'(if0.x));
  assign if0.f2 = f2_of(mode[0], int'(if0.x));
  assign if1.f1 = f1_of(mode[1], int'(if1.x));
  assign if1.f2 = f2_of(mode[1], int'(if1.x));
  assign if2.f1 = f1_of(mode[2], int'(if2.x));
  assign if2.f2 = f2_of(mode[2], int'(if2.x));

  exhaustive_equiv_checker #(.N(4), .SETTLE(1)) u0 (.Clock(clk), .Reset(rst), .bus(if0));
  exhaustive_equiv_checker #(.N(4), .SETTLE(3)) u1 (.Clock(clk), .Reset(rst), .bus(if1));
  exhaustive_equiv_checker #(.N(1), .SETTLE(1)) u2 (.Clock(clk), .Reset(rst), .bus(if2));

  // ---------------- access helpers ----------------
  function automatic logic get_start(input int i);
    case (i)
      0:       return if0.start;
      1:       return if1.start;
      default: return if2.start;
    endcase
  endfunction

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       if0.start = v;
      1:       if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic get(input int i, output int x, output int busy, output int done,
                     output int pass, output int err, output int fv, output int ff);
    case (i)
      0: begin
        x = int'(if0.x); busy = int'(if0.busy); done = int'(if0.done); pass = int'(if0.pass);
        err = int'(if0.err_count); fv = int'(if0.fail_valid); ff = int'(if0.first_fail);
      end
      1: begin
        x = int'(if1.x); busy = int'(if1.busy); done = int'(if1.done); pass = int'(if1.pass);
        err = int'(if1.err_count); fv = int'(if1.fail_valid); ff = int'(if1.first_fail);
      end
      default: begin
        x = int'(if2.x); busy = int'(if2.busy); done = int'(if2.done); pass = int'(if2.pass);
        err = int'(if2.err_count); fv = int'(if2.fail_valid); ff = int'(if2.first_fail);
      end
    endcase
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // ---------------- behavioural model: run phase per instance ----------------
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int tot;
      tot = (1 << NV[i]) * (SV[i] + 1);
      if (rst)                                           ph[i] <= -1;
      else if ((ph[i] < 0 || ph[i] >= tot) && get_start(i)) ph[i] <= 0;
      else if (ph[i] >= 0 && ph[i] < tot)                 ph[i] <= ph[i] + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      int tot, nv, ex, eb, ed, ee, g_x, g_b, g_d, g_p, g_e, g_v, g_f;
      tot = (1 << NV[i]) * (SV[i] + 1);
      if (ph[i] < 0) begin
        nv = 0; ex = 0; eb = 0; ed = 0;
      end else if (ph[i] < tot) begin
        nv = ph[i] / (SV[i] + 1); ex = nv; eb = 1; ed = 0;
      end else begin
        nv = 1 << NV[i]; ex = nv - 1; eb = 0; ed = 1;
      end
      ee = exp_err(mode[i], nv);
      get(i, g_x, g_b, g_d, g_p, g_e, g_v, g_f);
      chk($sformatf("u%0d.x ph=%0d", i, ph[i]), g_x, ex);
      chk($sformatf("u%0d.busy ph=%0d", i, ph[i]), g_b, eb);
      chk($sformatf("u%0d.done ph=%0d", i, ph[i]), g_d, ed);
      chk($sformatf("u%0d.pass ph=%0d", i, ph[i]), g_p, (ed == 1 && ee == 0) ? 1 : 0);
      chk($sformatf("u%0d.err_count ph=%0d", i, ph[i]), g_e, ee);
      chk($sformatf("u%0d.fail_valid ph=%0d", i, ph[i]), g_v, (ee != 0) ? 1 : 0);
      chk($sformatf("u%0d.first_fail ph=%0d", i, ph[i]), g_f, exp_first(mode[i], nv));
    end
  end

  // ---------------- directed stimulus ----------------
  // Pulses start with mode m; lat = edges after start-accept until done seen.
  task automatic run(input int i, input int m, input int bound, output int lat);
    int x, b, d, p, e, v, f;
    @(negedge clk);
    mode[i] = m;
    set_start(i, 1'b1);
    @(negedge clk);
    set_start(i, 1'b0);
    lat = 0;
    get(i, x, b, d, p, e, v, f);
    while (d == 0 && lat < bound) begin
      @(negedge clk);
      lat++;
      get(i, x, b, d, p, e, v, f);
    end
  endtask

  initial begin
    int lat, x, b, d, p, e, v, f;
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    get(0, x, b, d, p, e, v, f);
    chk("reset x", x, 0);
    chk("reset busy", b, 0);
    chk("reset err_count", e, 0);

    // 1: equal functions
    run(0, 0, 200, lat);
    get(0, x, b, d, p, e, v, f);
    chk("t1 latency", lat, 32);
    chk("t1 pass", p, 1);
    chk("t1 err_count", e, 0);
    chk("t1 fail_valid", v, 0);
    chk("t1 x", x, 15);

    // 2: single mismatch at 4'b1010
    run(0, 1, 200, lat);
    get(0, x, b, d, p, e, v, f);
    chk("t2 err_count", e, 1);
    chk("t2 first_fail", f, 10);
    chk("t2 fail_valid", v, 1);
    chk("t2 pass", p, 0);

    // 3: complemented function, every vector mismatches
    run(0, 2, 200, lat);
    get(0, x, b, d, p, e, v, f);
    chk("t3 err_count", e, 16);
    chk("t3 first_fail", f, 0);
    chk("t3 pass", p, 0);

    // AND vs OR: mismatch where exactly one of x1,x2 is set
    run(0, 3, 200, lat);
    get(0, x, b, d, p, e, v, f);
    chk("and_or err_count", e, 8);
    chk("and_or first_fail", f, 1);

    // 4: reset mid-run, then a fresh run
    @(negedge clk);
    mode[0] = 2;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    get(0, x, b, d, p, e, v, f);
    chk("t4 reset busy", b, 0);
    chk("t4 reset x", x, 0);
    chk("t4 reset err_count", e, 0);
    chk("t4 reset fail_valid", v, 0);
    run(0, 1, 200, lat);
    get(0, x, b, d, p, e, v, f);
    chk("t4 latency", lat, 32);
    chk("t4 err_count", e, 1);
    chk("t4 first_fail", f, 10);

    // 5: start held high across a whole run and into a restart
    @(negedge clk);
    mode[0] = 1;
    if0.start = 1'b1;
    @(negedge clk);
    lat = 0;
    get(0, x, b, d, p, e, v, f);
    while (d == 0 && lat < 200) begin @(negedge clk); lat++; get(0, x, b, d, p, e, v, f); end
    chk("t5 held latency", lat, 32);
    chk("t5 held err_count", e, 1);
    @(negedge clk);
    get(0, x, b, d, p, e, v, f);
    chk("t5 restart done", d, 0);
    chk("t5 restart busy", b, 1);
    chk("t5 restart err_count", e, 0);
    lat = 0;
    while (d == 0 && lat < 200) begin @(negedge clk); lat++; get(0, x, b, d, p, e, v, f); end
    chk("t5 second latency", lat, 32);
    if0.start = 1'b0;
    @(negedge clk);
    get(0, x, b, d, p, e, v, f);
    chk("t5 done held", d, 1);
    chk("t5 x held", x, 15);

    // 5: SETTLE=3 and N=1 run lengths
    run(1, 0, 300, lat);
    get(1, x, b, d, p, e, v, f);
    chk("u1 latency", lat, 64);
    chk("u1 pass", p, 1);
    run(2, 0, 50, lat);
    get(2, x, b, d, p, e, v, f);
    chk("u2 latency", lat, 4);
    chk("u2 pass", p, 1);
    run(2, 2, 50, lat);
    get(2, x, b, d, p, e, v, f);
    chk("u2 compl latency", lat, 4);
    chk("u2 compl err_count", e, 2);
    chk("u2 compl first_fail", f, 0);
    chk("u2 compl pass", p, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
